// File: rtl/root_job_dispatcher.sv
// root_job_dispatcher
// Front-end for the fixed-point n-th root core. Root requests arrive on a
// valid/ready stream and are queued in a small FIFO. Jobs go to the core one
// at a time, and results come back on a valid/ready response stream together
// with the request tag, the measured latency and an error flag. Degree 0 is
// rejected without starting the core. A watchdog fails jobs that take too long.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   req_valid/ready     request handshake (req_ready = !fifo_full)
//   req_radicand        10-bit integer radicand
//   req_degree          3-bit root degree
//   rsp_valid/ready     response handshake
//   rsp_root            Q10.10 result (20'hFFFFF on timeout, 0 on degree 0)
//   rsp_tag             sequence tag of the answered request
//   rsp_err             1 = degree 0 or timeout
//   rsp_cycles          cycles from issue to core completion
//   core_in_valid       one-cycle start pulse to the core
//   core_data_1/2       radicand / degree, held stable while the core works
//   core_out_valid/data core completion pulse and result
module root_job_dispatcher #(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int CNT_W   = 12,
    parameter int TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [9:0]       req_radicand,
    input  logic [2:0]       req_degree,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [19:0]      rsp_root,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err,
    output logic [CNT_W-1:0] rsp_cycles,
    output logic             core_in_valid,
    output logic [9:0]       core_data_1,
    output logic [2:0]       core_data_2,
    input  logic             core_out_valid,
    input  logic [19:0]      core_out_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = 10 + 3 + TAG_W;
    localparam logic [PTR_W:0]   FULL_CNT    = (PTR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP,
        ST_DRAIN
    } state_e;

    state_e            state_q, state_d;

    logic [ENT_W-1:0]  fifo_mem_q [DEPTH];
    logic [ENT_W-1:0]  fifo_mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic [TAG_W-1:0]  tag_q, tag_d;

    logic [9:0]        op_radicand_q, op_radicand_d;
    logic [2:0]        op_degree_q, op_degree_d;
    logic [TAG_W-1:0]  cur_tag_q, cur_tag_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [19:0]       rsp_root_q, rsp_root_d;
    logic              rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0]  rsp_cycles_q, rsp_cycles_d;
    logic              drain_pending_q, drain_pending_d;

    logic              fifo_full, fifo_empty;
    logic              push, pop;
    logic [ENT_W-1:0]  head;
    logic [9:0]        head_radicand;
    logic [2:0]        head_degree;
    logic [TAG_W-1:0]  head_tag;

    assign fifo_full  = (count_q == FULL_CNT);
    assign fifo_empty = (count_q == '0);
    assign push       = req_valid && !fifo_full;
    // The FIFO head is only consumed from IDLE, one job at a time.
    assign pop        = (state_q == ST_IDLE) && !fifo_empty;

    assign head          = fifo_mem_q[rd_ptr_q];
    assign head_radicand = head[ENT_W-1 -: 10];
    assign head_degree   = head[TAG_W +: 3];
    assign head_tag      = head[TAG_W-1:0];

    // FIFO storage, pointers, occupancy and the request tag counter.
    always_comb begin
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        tag_d      = tag_q;
        if (push) begin
            fifo_mem_d[wr_ptr_q] = {req_radicand, req_degree, tag_q};
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            tag_d    = tag_q + TAG_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Job sequencing: load operands, start the core, collect the result or
    // time out, present the response, and after a timeout swallow the late
    // core completion before the next job may start.
    always_comb begin
        state_d         = state_q;
        op_radicand_d   = op_radicand_q;
        op_degree_d     = op_degree_q;
        cur_tag_d       = cur_tag_q;
        cnt_d           = cnt_q;
        rsp_root_d      = rsp_root_q;
        rsp_err_d       = rsp_err_q;
        rsp_cycles_d    = rsp_cycles_q;
        drain_pending_d = drain_pending_q;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    op_radicand_d = head_radicand;
                    op_degree_d   = head_degree;
                    cur_tag_d     = head_tag;
                    if (head_degree == 3'd0) begin
                        rsp_root_d   = 20'h00000;
                        rsp_err_d    = 1'b1;
                        rsp_cycles_d = '0;
                        state_d      = ST_RESP;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                cnt_d   = CNT_W'(1);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (core_out_valid) begin
                    rsp_root_d   = core_out_data;
                    rsp_err_d    = 1'b0;
                    rsp_cycles_d = cnt_q;
                    state_d      = ST_RESP;
                end else if (cnt_q == TIMEOUT_CNT) begin
                    // The core is still busy; remember to wait for its
                    // completion before issuing anything new.
                    rsp_root_d      = 20'hFFFFF;
                    rsp_err_d       = 1'b1;
                    rsp_cycles_d    = TIMEOUT_CNT;
                    drain_pending_d = 1'b1;
                    state_d         = ST_RESP;
                end
            end
            ST_RESP: begin
                if (core_out_valid && drain_pending_q) begin
                    drain_pending_d = 1'b0;
                end
                if (rsp_ready) begin
                    state_d = drain_pending_d ? ST_DRAIN : ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (core_out_valid) begin
                    drain_pending_d = 1'b0;
                    state_d         = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FIFO payload needs no reset; only the pointers define its contents.
    always_ff @(posedge clk) begin
        fifo_mem_q <= fifo_mem_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            tag_q           <= '0;
            op_radicand_q   <= '0;
            op_degree_q     <= '0;
            cur_tag_q       <= '0;
            cnt_q           <= '0;
            rsp_root_q      <= '0;
            rsp_err_q       <= 1'b0;
            rsp_cycles_q    <= '0;
            drain_pending_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            tag_q           <= tag_d;
            op_radicand_q   <= op_radicand_d;
            op_degree_q     <= op_degree_d;
            cur_tag_q       <= cur_tag_d;
            cnt_q           <= cnt_d;
            rsp_root_q      <= rsp_root_d;
            rsp_err_q       <= rsp_err_d;
            rsp_cycles_q    <= rsp_cycles_d;
            drain_pending_q <= drain_pending_d;
        end
    end

    assign req_ready     = !fifo_full;
    assign rsp_valid     = (state_q == ST_RESP);
    assign rsp_root      = rsp_root_q;
    assign rsp_tag       = cur_tag_q;
    assign rsp_err       = rsp_err_q;
    assign rsp_cycles    = rsp_cycles_q;
    assign core_in_valid = (state_q == ST_ISSUE);
    assign core_data_1   = op_radicand_q;
    assign core_data_2   = op_degree_q;

endmodule

// File: tb/tb_root_job_dispatcher.sv
// tb_root_job_dispatcher
// Directed bench for root_job_dispatcher with a behavioural root core stub
// whose latency is set per job, a response logger and operand/spacing
// monitors. Expected values are hand-computed constants.
module tb_root_job_dispatcher;

    localparam int DEPTH   = 4;
    localparam int TAG_W   = 4;
    localparam int CNT_W   = 12;
    localparam int TIMEOUT = 20;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [9:0]       req_radicand = '0;
    logic [2:0]       req_degree = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [19:0]      rsp_root;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_err;
    logic [CNT_W-1:0] rsp_cycles;
    logic             core_in_valid;
    logic [9:0]       core_data_1;
    logic [2:0]       core_data_2;
    logic             core_out_valid = 1'b0;
    logic [19:0]      core_out_data = '0;

    always #5 clk = ~clk;

    root_job_dispatcher #(
        .DEPTH(DEPTH), .TAG_W(TAG_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_radicand(req_radicand), .req_degree(req_degree),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_root(rsp_root), .rsp_tag(rsp_tag), .rsp_err(rsp_err),
        .rsp_cycles(rsp_cycles),
        .core_in_valid(core_in_valid), .core_data_1(core_data_1),
        .core_data_2(core_data_2),
        .core_out_valid(core_out_valid), .core_out_data(core_out_data)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Floor of x^(1/n) in Q10.10, for degrees 1..3.
    function automatic logic [19:0] root_model(input logic [9:0] x, input logic [2:0] n);
        longint unsigned target;
        longint unsigned p;
        logic [19:0] r;
        logic [19:0] cand;
        r = '0;
        if (n == 3'd0 || n > 3'd3) return '0;
        target = longint'(x) << (10 * int'(n));
        for (int b = 19; b >= 0; b--) begin
            cand = r | (20'd1 << b);
            p = 1;
            for (int k = 0; k < int'(n); k++) p = p * longint'(cand);
            if (p <= target) r = cand;
        end
        return r;
    endfunction

    // Core stub: latches its latency at the start pulse, computes from the
    // live operands at completion, and watches operand stability and the
    // minimum out_valid-to-next-start spacing.
    int          cyc = 0;
    int          core_lat = 5;
    int          lat_cur = 0;
    int          core_cnt = 0;
    logic        core_busy = 1'b0;
    logic [9:0]  lat_rad = '0;
    logic [2:0]  lat_deg = '0;
    int          issue_count = 0;
    int          last_ov_cyc = -100;
    int          last_issue_cyc = 0;
    int          last_gap = 0;
    int          spacing_viol = 0;
    int          operand_viol = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        core_out_valid <= 1'b0;
        if (!rst_n) begin
            core_busy <= 1'b0;
            core_out_data <= '0;
        end else begin
            if (core_out_valid) begin
                last_ov_cyc <= cyc;
                last_gap <= cyc - last_issue_cyc;
            end
            if (core_in_valid) begin
                issue_count <= issue_count + 1;
                last_issue_cyc <= cyc;
                if (cyc - last_ov_cyc < 2) spacing_viol <= spacing_viol + 1;
                core_busy <= 1'b1;
                core_cnt <= 1;
                lat_cur <= core_lat;
                lat_rad <= core_data_1;
                lat_deg <= core_data_2;
            end else if (core_busy) begin
                if (core_data_1 !== lat_rad || core_data_2 !== lat_deg)
                    operand_viol <= operand_viol + 1;
                if (core_cnt >= lat_cur) begin
                    core_out_valid <= 1'b1;
                    core_out_data <= root_model(core_data_1, core_data_2);
                    core_busy <= 1'b0;
                end else begin
                    core_cnt <= core_cnt + 1;
                end
            end
        end
    end

    typedef struct packed {
        logic [19:0]      root;
        logic [TAG_W-1:0] tag;
        logic             err;
        logic [CNT_W-1:0] cycles;
    } rsp_entry_t;

    rsp_entry_t rsp_log[$];
    int         rsp_base = 0;
    int         issue_base = 0;

    always @(posedge clk) begin
        if (rst_n && rsp_valid && rsp_ready)
            rsp_log.push_back(rsp_entry_t'({rsp_root, rsp_tag, rsp_err, rsp_cycles}));
    end

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rsp_base = rsp_log.size();
        issue_base = issue_count;
    endtask

    // Present one request and hold it until accepted (bounded).
    task automatic applyStimulus(input logic [9:0] rad, input logic [2:0] deg);
        int waited = 0;
        req_valid = 1'b1;
        req_radicand = rad;
        req_degree = deg;
        while (!req_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("push_accepted", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic waitResp(input string tag, input int n, input int budget);
        int waited = 0;
        while (rsp_log.size() < rsp_base + n && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        checkOutput(tag, 32'(rsp_log.size() - rsp_base), 32'(n));
    endtask

    task automatic waitIssues(input int n, input int budget);
        int waited = 0;
        while (issue_count - issue_base < n && waited < budget) begin
            @(negedge clk);
            waited++;
        end
    endtask

    task automatic checkResp(input string tag, input int idx, input logic [19:0] root,
                             input int rtag, input logic err, input int cycles);
        rsp_entry_t e;
        if (rsp_base + idx < rsp_log.size()) e = rsp_log[rsp_base + idx];
        else e = '1;
        checkOutput({tag, "_root"}, 32'(e.root), 32'(root));
        checkOutput({tag, "_tag"}, 32'(e.tag), 32'(rtag));
        checkOutput({tag, "_err"}, 32'(e.err), 32'(err));
        checkOutput({tag, "_cycles"}, 32'(e.cycles), 32'(cycles));
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        checkOutput({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        checkOutput({tag, "_rsp_root"}, 32'(rsp_root), 32'd0);
        checkOutput({tag, "_rsp_tag"}, 32'(rsp_tag), 32'd0);
        checkOutput({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
        checkOutput({tag, "_rsp_cycles"}, 32'(rsp_cycles), 32'd0);
        checkOutput({tag, "_core_in_valid"}, 32'(core_in_valid), 32'd0);
        checkOutput({tag, "_core_data_1"}, 32'(core_data_1), 32'd0);
        checkOutput({tag, "_core_data_2"}, 32'(core_data_2), 32'd0);
    endtask

    initial begin
        int accepted;

        // Reset state
        repeat (2) @(negedge clk);
        checkIdleOutputs("rst");
        rst_n = 1'b1;
        rsp_base = rsp_log.size();
        issue_base = issue_count;

        // Single cube root: 27^(1/3) = 3.0
        rsp_ready = 1'b1;
        applyStimulus(10'd27, 3'd3);
        waitResp("t1_count", 1, 100);
        checkResp("t1", 0, 20'h00C00, 0, 1'b0, 6);
        checkOutput("t1_cycles_vs_gap", 32'(rsp_log[rsp_base].cycles), 32'(last_gap));
        checkOutput("t1_issues", 32'(issue_count - issue_base), 32'd1);

        // Back-to-back requests, responses in order
        doReset();
        applyStimulus(10'd16, 3'd2);
        applyStimulus(10'd5, 3'd1);
        applyStimulus(10'd0, 3'd2);
        waitResp("t2_count", 3, 200);
        checkResp("t2_a", 0, 20'h01000, 0, 1'b0, 6);
        checkResp("t2_b", 1, 20'h01400, 1, 1'b0, 6);
        checkResp("t2_c", 2, 20'h00000, 2, 1'b0, 6);
        checkOutput("t2_issues", 32'(issue_count - issue_base), 32'd3);

        // Degree 0 is rejected without starting the core
        doReset();
        applyStimulus(10'd8, 3'd0);
        waitResp("t3_count", 1, 50);
        checkResp("t3", 0, 20'h00000, 0, 1'b1, 0);
        repeat (10) @(negedge clk);
        checkOutput("t3_issues", 32'(issue_count - issue_base), 32'd0);

        // Backpressure: DEPTH queued plus one in flight, then drain
        doReset();
        rsp_ready = 1'b0;
        accepted = 0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            req_valid = 1'b1;
            req_radicand = 10'(i + 1);
            req_degree = 3'd1;
            if (req_ready) accepted++;
            @(negedge clk);
        end
        checkOutput("t4_accepts", 32'(accepted), 32'(DEPTH + 1));
        checkOutput("t4_req_ready_full", 32'(req_ready), 32'd0);
        req_valid = 1'b0;
        repeat (15) @(negedge clk);
        checkOutput("t4_rsp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("t4_hold_root_a", 32'(rsp_root), 32'h00400);
        repeat (10) @(negedge clk);
        checkOutput("t4_hold_root_b", 32'(rsp_root), 32'h00400);
        checkOutput("t4_hold_tag", 32'(rsp_tag), 32'd0);
        checkOutput("t4_hold_cycles", 32'(rsp_cycles), 32'd6);
        checkOutput("t4_still_full", 32'(req_ready), 32'd0);
        rsp_ready = 1'b1;
        waitResp("t4_count", DEPTH + 1, 300);
        for (int i = 0; i < DEPTH + 1; i++)
            checkResp($sformatf("t4_%0d", i), i, 20'((i + 1) << 10), i, 1'b0, 6);

        // Watchdog timeout, drain of the late completion, then normal issue
        doReset();
        rsp_ready = 1'b1;
        core_lat = 60;
        applyStimulus(10'd27, 3'd3);
        applyStimulus(10'd16, 3'd2);
        waitIssues(1, 50);
        core_lat = 5;
        waitResp("t5_count_a", 1, 100);
        checkResp("t5_a", 0, 20'hFFFFF, 0, 1'b1, TIMEOUT);
        repeat (30) @(negedge clk);
        checkOutput("t5_no_issue_in_drain", 32'(issue_count - issue_base), 32'd1);
        waitResp("t5_count_b", 2, 100);
        checkResp("t5_b", 1, 20'h01000, 1, 1'b0, 6);
        checkOutput("t5_issues", 32'(issue_count - issue_base), 32'd2);

        // Reset in the middle of a job
        doReset();
        rsp_ready = 1'b1;
        applyStimulus(10'd27, 3'd3);
        waitIssues(1, 50);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checkIdleOutputs("t6");
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("t6_no_stale_rsp", 32'(rsp_log.size() - rsp_base), 32'd0);
        checkOutput("t6_no_reissue", 32'(issue_count - issue_base), 32'd1);
        checkOutput("t6_req_ready", 32'(req_ready), 32'd1);

        // Tag counter wraps modulo 2^TAG_W
        doReset();
        rsp_ready = 1'b1;
        for (int i = 0; i < 17; i++) applyStimulus(10'(i), 3'd0);
        waitResp("t7_count", 17, 400);
        checkResp("t7_15", 15, 20'h00000, 15, 1'b1, 0);
        checkResp("t7_16", 16, 20'h00000, 0, 1'b1, 0);

        checkOutput("operand_stable", 32'(operand_viol), 32'd0);
        checkOutput("issue_spacing", 32'(spacing_viol), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
